// File: rtl/interstage_reg_bank_pkg.sv
// Shared definitions for the interstage register bank: default sizes,
// named channel indices and the per-channel operation decode.
package interstage_reg_bank_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int NUM_REGS_DEF = 4;
  localparam int AGE_BITS_DEF = 3;

  // Named channel slots of the default four-channel bank.
  localparam int CH_IR  = 0;
  localparam int CH_MDR = 1;
  localparam int CH_A   = 2;
  localparam int CH_B   = 3;

  // Operation a channel performs on the next edge.
  typedef enum logic [1:0] {
    CH_OP_HOLD    = 2'd0,
    CH_OP_WRITE   = 2'd1,
    CH_OP_CLEAR   = 2'd2,
    CH_OP_RESTORE = 2'd3
  } ch_op_e;

  // Resolve competing requests: restore beats clear, clear beats write.
  function automatic ch_op_e decode_op(input logic restore,
                                       input logic clear,
                                       input logic write);
    ch_op_e op;
    if (restore) begin
      op = CH_OP_RESTORE;
    end else if (clear) begin
      op = CH_OP_CLEAR;
    end else if (write) begin
      op = CH_OP_WRITE;
    end else begin
      op = CH_OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/interstage_reg_bank_reg_channel.sv
// One channel of the interstage bank: data, valid flag and a saturating
// age counter, with restore > clear > write > hold priority.
module reg_channel
  import interstage_reg_bank_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int AGE_BITS = AGE_BITS_DEF
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                write_en,
  input  logic                clear_en,
  input  logic                restore_en,
  input  logic [WIDTH-1:0]    write_data,
  input  logic [WIDTH-1:0]    restore_data,
  input  logic                restore_valid,
  output logic [WIDTH-1:0]    data,
  output logic                valid,
  output logic [AGE_BITS-1:0] age
);

  localparam logic [AGE_BITS-1:0] AGE_MAX  = {AGE_BITS{1'b1}};
  localparam logic [AGE_BITS-1:0] AGE_ONE  = AGE_BITS'(1);
  localparam logic [AGE_BITS-1:0] AGE_ZERO = {AGE_BITS{1'b0}};
  localparam logic [WIDTH-1:0]    DATA_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0]    data_r;
  logic                valid_r;
  logic [AGE_BITS-1:0] age_r;

  ch_op_e              op_s;
  logic [WIDTH-1:0]    data_nxt_s;
  logic                valid_nxt_s;
  logic [AGE_BITS-1:0] age_nxt_s;

  // Next-state selection for data, valid and age from the decoded operation.
  always_comb begin
    op_s        = decode_op(restore_en, clear_en, write_en);
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    age_nxt_s   = age_r;
    case (op_s)
      CH_OP_RESTORE: begin
        data_nxt_s  = restore_data;
        valid_nxt_s = restore_valid;
        age_nxt_s   = AGE_ZERO;
      end
      CH_OP_CLEAR: begin
        data_nxt_s  = DATA_ZERO;
        valid_nxt_s = 1'b0;
        age_nxt_s   = AGE_ZERO;
      end
      CH_OP_WRITE: begin
        data_nxt_s  = write_data;
        valid_nxt_s = 1'b1;
        age_nxt_s   = AGE_ZERO;
      end
      CH_OP_HOLD: begin
        // Only valid data ages; the counter sticks at its maximum.
        if (!valid_r) begin
          age_nxt_s = AGE_ZERO;
        end else if (age_r != AGE_MAX) begin
          age_nxt_s = age_r + AGE_ONE;
        end else begin
          age_nxt_s = age_r;
        end
      end
      default: begin
        data_nxt_s  = data_r;
        valid_nxt_s = valid_r;
        age_nxt_s   = age_r;
      end
    endcase
  end

  // Channel state registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      data_r  <= DATA_ZERO;
      valid_r <= 1'b0;
      age_r   <= AGE_ZERO;
    end else begin
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      age_r   <= age_nxt_s;
    end
  end

  assign data  = data_r;
  assign valid = valid_r;
  assign age   = age_r;

endmodule

// File: rtl/interstage_reg_bank.sv
// Bank of independent pipeline registers with a single shared shadow copy
// that can be snapshotted and later restored into every channel at once.
module interstage_reg_bank
  import interstage_reg_bank_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int AGE_BITS = AGE_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic [NUM_REGS-1:0]          writeControl,
  input  logic [NUM_REGS*WIDTH-1:0]    inputData,
  input  logic [NUM_REGS-1:0]          clearControl,
  input  logic                         snapshotControl,
  input  logic                         restoreControl,
  output logic [NUM_REGS*WIDTH-1:0]    outputData,
  output logic [NUM_REGS-1:0]          validFlags,
  output logic [NUM_REGS*AGE_BITS-1:0] regAge,
  output logic                         snapshotValid
);

  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0]    ch_data_s   [NUM_REGS];
  logic [NUM_REGS-1:0] ch_valid_s;
  logic [WIDTH-1:0]    shadow_data_r [NUM_REGS];
  logic [NUM_REGS-1:0] shadow_valid_r;
  logic                snap_valid_r;
  logic                restore_honoured_s;

  // A restore request only counts while an unconsumed snapshot exists.
  assign restore_honoured_s = restoreControl & snap_valid_r;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_ch
    reg_channel #(
      .WIDTH    (WIDTH),
      .AGE_BITS (AGE_BITS)
    ) u_ch (
      .clk           (clk),
      .resetN        (resetN),
      .write_en      (writeControl[i]),
      .clear_en      (clearControl[i]),
      .restore_en    (restore_honoured_s),
      .write_data    (inputData[i*WIDTH +: WIDTH]),
      .restore_data  (shadow_data_r[i]),
      .restore_valid (shadow_valid_r[i]),
      .data          (ch_data_s[i]),
      .valid         (ch_valid_s[i]),
      .age           (regAge[i*AGE_BITS +: AGE_BITS])
    );
    assign outputData[i*WIDTH +: WIDTH] = ch_data_s[i];
  end

  assign validFlags = ch_valid_s;

  // Shadow bank: capture pre-edge channel contents on snapshot; an honoured
  // restore consumes the snapshot and suppresses any concurrent capture.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_data_r[i] <= DATA_ZERO;
      end
      shadow_valid_r <= {NUM_REGS{1'b0}};
      snap_valid_r   <= 1'b0;
    end else if (restore_honoured_s) begin
      snap_valid_r <= 1'b0;
    end else if (snapshotControl) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_data_r[i] <= ch_data_s[i];
      end
      shadow_valid_r <= ch_valid_s;
      snap_valid_r   <= 1'b1;
    end else begin
      snap_valid_r <= snap_valid_r;
    end
  end

  assign snapshotValid = snap_valid_r;

endmodule

// File: tb/tb_interstage_reg_bank.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// against an array-based behavioural model of the bank.
module tb_interstage_reg_bank;

  localparam int NA = 4;
  localparam int WA = 8;
  localparam int AB = 3;
  localparam int AMAX = (1 << AB) - 1;
  localparam int NB = 6;
  localparam int WB = 16;

  logic clk = 1'b0;
  logic resetN;

  logic [NA-1:0]    wc, cc;
  logic [NA*WA-1:0] din;
  logic             snap, rest;
  logic [NA*WA-1:0] dout;
  logic [NA-1:0]    vf;
  logic [NA*AB-1:0] age;
  logic             sv;

  logic [NB-1:0]    b_wc, b_cc;
  logic [NB*WB-1:0] b_din;
  logic             b_snap, b_rest;
  logic [NB*WB-1:0] b_dout;
  logic [NB-1:0]    b_vf;
  logic [NB*AB-1:0] b_age;
  logic             b_sv;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the default bank
  int m_data[NA], m_valid[NA], m_age[NA];
  int s_data[NA], s_valid[NA];
  int m_sv;
  logic [WB-1:0] b_exp[NB];

  always #5 clk = ~clk;

  interstage_reg_bank dut_a (
    .clk(clk), .resetN(resetN), .writeControl(wc), .inputData(din),
    .clearControl(cc), .snapshotControl(snap), .restoreControl(rest),
    .outputData(dout), .validFlags(vf), .regAge(age), .snapshotValid(sv)
  );

  interstage_reg_bank #(.WIDTH(WB), .NUM_REGS(NB), .AGE_BITS(AB)) dut_b (
    .clk(clk), .resetN(resetN), .writeControl(b_wc), .inputData(b_din),
    .clearControl(b_cc), .snapshotControl(b_snap), .restoreControl(b_rest),
    .outputData(b_dout), .validFlags(b_vf), .regAge(b_age), .snapshotValid(b_sv)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_data[i] = 0; m_valid[i] = 0; m_age[i] = 0; s_data[i] = 0; s_valid[i] = 0;
    end
    m_sv = 0;
  endtask

  // One rising edge of the model, using the inputs currently applied.
  task automatic model_step();
    int pre_d[NA], pre_v[NA];
    bit honour;
    honour = rest && (m_sv != 0);
    for (int i = 0; i < NA; i++) begin
      pre_d[i] = m_data[i]; pre_v[i] = m_valid[i];
    end
    for (int i = 0; i < NA; i++) begin
      if (honour) begin
        m_data[i] = s_data[i]; m_valid[i] = s_valid[i]; m_age[i] = 0;
      end else if (cc[i]) begin
        m_data[i] = 0; m_valid[i] = 0; m_age[i] = 0;
      end else if (wc[i]) begin
        m_data[i] = int'(din[i*WA +: WA]); m_valid[i] = 1; m_age[i] = 0;
      end else if (m_valid[i] != 0) begin
        m_age[i] = (m_age[i] < AMAX) ? m_age[i] + 1 : AMAX;
      end
    end
    if (honour) begin
      m_sv = 0;
    end else if (snap) begin
      for (int i = 0; i < NA; i++) begin
        s_data[i] = pre_d[i]; s_valid[i] = pre_v[i];
      end
      m_sv = 1;
    end
  endtask

  task automatic check_a(input string tag);
    logic [NA*WA-1:0] ed;
    logic [NA-1:0]    ev;
    logic [NA*AB-1:0] ea;
    for (int i = 0; i < NA; i++) begin
      ed[i*WA +: WA] = WA'(m_data[i]);
      ev[i]          = (m_valid[i] != 0);
      ea[i*AB +: AB] = AB'(m_age[i]);
    end
    check({tag, ".data"},  128'(dout), 128'(ed));
    check({tag, ".valid"}, 128'(vf),   128'(ev));
    check({tag, ".age"},   128'(age),  128'(ea));
    check({tag, ".snapv"}, 128'(sv),   128'(m_sv != 0));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_a(tag);
  endtask

  task automatic set_in(input logic [3:0] w, input logic [3:0] c, input logic [31:0] d,
                        input logic s, input logic r);
    wc = w; cc = c; din = d; snap = s; rest = r;
  endtask

  initial begin
    resetN = 1'b0;
    set_in(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    b_wc = '0; b_cc = '0; b_din = '0; b_snap = 1'b0; b_rest = 1'b0;
    model_reset();
    #12;
    check_a("reset");
    check("reset_b", 128'({b_dout, b_vf, b_age, b_sv}), 128'(0));
    @(negedge clk);
    resetN = 1'b1;

    // Single write then saturation of the age counter
    set_in(4'b0001, 4'h0, 32'h000000A5, 1'b0, 1'b0);
    step("wr_ch0");
    check("req32_ch0", 128'(dout[7:0]), 128'(8'hA5));
    check("req32_valid", 128'(vf), 128'(4'b0001));
    set_in(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step("idle");
    check("req32_age_sat", 128'(age[2:0]), 128'(3'd7));

    // Clear beats write on the same channel
    set_in(4'b0100, 4'h0, 32'h003C0000, 1'b0, 1'b0);
    step("wr_ch2");
    set_in(4'b0100, 4'b0100, 32'h00FF0000, 1'b0, 1'b0);
    step("clr_wr_ch2");
    check("req33_ch2", 128'(dout[23:16]), 128'(8'h00));
    check("req33_valid2", 128'(vf[2]), 128'(1'b0));

    // Snapshot / restore round trip
    set_in(4'b0010, 4'h0, 32'h00001100, 1'b0, 1'b0);
    step("wr_ch1_11");
    set_in(4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    step("snapshot");
    set_in(4'b0010, 4'h0, 32'h00002200, 1'b0, 1'b0);
    step("wr_ch1_22");
    set_in(4'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    step("restore");
    check("req34_ch1", 128'(dout[15:8]), 128'(8'h11));
    check("req34_age1", 128'(age[5:3]), 128'(3'd0));
    check("req34_snapv", 128'(sv), 128'(1'b0));
    set_in(4'b1000, 4'h0, 32'h55000000, 1'b0, 1'b1);
    step("restore2_wr");
    check("req34_ch1_again", 128'(dout[15:8]), 128'(8'h11));
    check("req34_ch3_wr", 128'(dout[31:24]), 128'(8'h55));

    // Restore without snapshot is a no-op
    set_in(4'b1000, 4'h0, 32'h7E000000, 1'b0, 1'b1);
    step("restore_nosnap");
    check("req35_ch3", 128'(dout[31:24]), 128'(8'h7E));
    check("req35_snapv", 128'(sv), 128'(1'b0));

    // Asynchronous reset discards a pending snapshot
    set_in(4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    step("snapshot2");
    check("req36_snapv_set", 128'(sv), 128'(1'b1));
    set_in(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    check_a("async_reset");
    check("req36_all_zero", 128'({dout, vf, age, sv}), 128'(0));
    @(negedge clk);
    resetN = 1'b1;
    set_in(4'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    step("restore_after_reset");
    check("req36_noop", 128'({dout, vf, sv}), 128'(0));

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      set_in(4'($urandom & $urandom & $urandom),
             ($urandom_range(0, 3) == 0) ? 4'($urandom & $urandom) : 4'h0,
             32'($urandom),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) == 0));
      step("rand");
    end

    // Wide bank: distinct values in every slice at once
    set_in(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < NB; i++) begin
      b_exp[i] = 16'h1234 + 16'(i) * 16'h1111;
      b_din[i*WB +: WB] = b_exp[i];
    end
    b_wc = 6'b111111;
    step("wide_write_a_idle");
    for (int i = 0; i < NB; i++)
      check($sformatf("req37_slice%0d", i), 128'(b_dout[i*WB +: WB]), 128'(b_exp[i]));
    check("req37_valid", 128'(b_vf), 128'(6'b111111));
    b_wc = 6'b100000;
    b_cc = 6'b000001;
    b_din = '1;
    b_exp[5] = 16'hFFFF;
    b_exp[0] = 16'h0000;
    step("wide_partial_a_idle");
    for (int i = 0; i < NB; i++)
      check($sformatf("req37_iso%0d", i), 128'(b_dout[i*WB +: WB]), 128'(b_exp[i]));
    check("req37_valid2", 128'(b_vf), 128'(6'b111110));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interstage_reg_bank.md
INTERSTAGE_REG_BANK -- requirements
Module: interstage_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each channel.
REQ-002 Parameter NUM_REGS, default 4, number of independent channels.
REQ-003 Parameter AGE_BITS, default 3, width of each channel's saturating age counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 writeControl  in  NUM_REGS  per-channel write enable; bit i selects channel i.
REQ-007 inputData  in  NUM_REGS*WIDTH  packed write data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 clearControl  in  NUM_REGS  per-channel synchronous clear.
REQ-009 snapshotControl  in  1  copy all channels into the shadow bank.
REQ-010 restoreControl  in  1  reload all channels from the shadow bank.
REQ-011 outputData  out  NUM_REGS*WIDTH  registered channel contents, packed as inputData.
REQ-012 validFlags  out  NUM_REGS  channel i holds written (or restored-valid) data.
REQ-013 regAge  out  NUM_REGS*AGE_BITS  cycles since last write per channel; saturating.
REQ-014 snapshotValid  out  1  shadow bank holds an unconsumed snapshot.

Function
REQ-015 All outputs SHALL be driven from flops; there SHALL be no combinational path from any input to outputData, validFlags or regAge.
REQ-016 Per-channel priority on each edge SHALL be: restore (when honoured) > clear > write > hold.
REQ-017 Write: data <= inputData slice, valid <= 1, age <= 0; visible on outputs the cycle after the edge.
REQ-018 Clear: data <= 0, valid <= 0, age <= 0.
REQ-019 Hold: data and valid unchanged; age increments by 1 if valid=1, saturating at 2^AGE_BITS-1; age stays 0 if valid=0.
REQ-020 Snapshot (snapshotControl=1, restore not honoured): the shadow bank SHALL capture the pre-edge data and valid of every channel; snapshotValid <= 1; a new snapshot overwrites an older one.
REQ-021 Snapshot SHALL NOT alter the live channels; writes and clears in the same cycle proceed normally and are not captured.
REQ-022 Restore is honoured only when restoreControl=1 and snapshotValid=1: every channel loads shadow data and valid, age <= 0, snapshotValid <= 0; writeControl and clearControl are ignored that cycle.
REQ-023 restoreControl=1 with snapshotValid=0 SHALL be a no-op; per-channel write, clear and hold proceed normally.
REQ-024 Honoured restore together with snapshotControl=1: restore wins, no new snapshot is taken, and snapshotValid ends at 0.
REQ-025 writeControl and clearControl both set on one channel: clear wins.
REQ-026 Channels SHALL be fully independent except for the shared snapshot and restore controls.

Reset
REQ-027 While resetN=0, asynchronously: outputData=0, validFlags=0, regAge=0, shadow data and valid=0, snapshotValid=0.
REQ-028 Reset asserted mid-operation SHALL discard any pending snapshot; the first edge after release applies normal behaviour.
REQ-029 Release of resetN is synchronised to clk outside this block.

Structure
REQ-030 A shared package SHALL hold the WIDTH, NUM_REGS and AGE_BITS defaults and named channel indices (IR=0, MDR=1, A=2, B=3).
REQ-031 Sub-module reg_channel SHALL implement one channel: data, valid, age and priority logic; the top instantiates NUM_REGS copies and owns the shadow bank and snapshotValid.

Verification
REQ-032 Reset, then writeControl=4'b0001, inputData ch0=8'hA5 for one cycle -> next cycle ch0=8'hA5, valid=0001, age0=0; after 10 idle cycles age0=7 (saturated).
REQ-033 Channel 2 holds 8'h3C; assert writeControl[2]=1 and clearControl[2]=1 together -> ch2=8'h00, valid[2]=0.
REQ-034 Channel 1 holds 8'h11; snapshot; write ch1=8'h22; restore -> ch1=8'h11, age1=0, snapshotValid=0; a second restore leaves ch1=8'h11 and applies any concurrent write.
REQ-035 restoreControl=1 with snapshotValid=0 and a write of ch3=8'h7E -> ch3=8'h7E, snapshotValid stays 0.
REQ-036 Take a snapshot, then assert resetN=0 between edges -> all outputs 0 immediately; a restore after release is a no-op.
REQ-037 NUM_REGS=6, WIDTH=16: write distinct values to all channels in one cycle -> each value appears in its own slice with no cross-channel corruption.
